// File: rtl/captura_ie.sv
// Input-capture stage feeding the control panel: per-interface key synchronise and
// debounce, switch-code latching, timed session hold and rejection reporting.

module captura_ie_ch #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int ERR_CYCLES  = 25000000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] user_sw,
    input  logic [2:0] func_sw,
    input  logic       btn_n,
    input  logic       auto_ie,
    output logic [2:0] user,
    output logic [2:0] func,
    output logic       active,
    output logic       err
);
    localparam int               DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(ERR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, ACTIVE, ERROR} state_t;

    state_t           state;
    logic             sync1;
    logic             sync2;
    logic [1:0]       sync_vld;
    logic             armed;
    logic             deb_lvl;
    logic [DEB_W-1:0] deb_cnt;
    logic             press;
    logic [CNT_W-1:0] cnt;

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together on the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync_vld <= 2'b00;
        end else begin
            sync1    <= btn_n;
            sync2    <= sync1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // A key held through reset must be seen released before it can produce a press;
    // sync_vld marks when sync2 carries a real post-reset sample rather than its reset 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            deb_lvl <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_vld[1] && sync2) begin
                armed <= 1'b1;
            end
            if (sync2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_lvl <= sync2;
                deb_cnt <= '0;
                press   <= deb_lvl & armed;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            user   <= 3'b000;
            func   <= 3'b000;
            active <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press) begin
                        user  <= user_sw;
                        func  <= func_sw;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (auto_ie) begin
                        user  <= 3'b000;
                        func  <= 3'b000;
                        err   <= 1'b1;
                        state <= ERROR;
                    end else begin
                        active <= 1'b1;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Panel feedback is deliberately not looked at here.
                    if (press || cnt == HOLD_LAST) begin
                        user   <= 3'b000;
                        func   <= 3'b000;
                        active <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERROR: begin
                    if (cnt == ERR_LAST) begin
                        err   <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    user   <= 3'b000;
                    func   <= 3'b000;
                    active <= 1'b0;
                    err    <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

module captura_ie #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 50000000,
    parameter int ERR_CYCLES  = 25000000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ie1_user_sw,
    input  logic [2:0] ie1_func_sw,
    input  logic       ie1_btn_n,
    input  logic [2:0] ie2_user_sw,
    input  logic [2:0] ie2_func_sw,
    input  logic       ie2_btn_n,
    input  logic       auto_ie1,
    input  logic       auto_ie2,
    output logic [2:0] ie1_user,
    output logic [2:0] ie1_func,
    output logic [2:0] ie2_user,
    output logic [2:0] ie2_func,
    output logic       ie1_active,
    output logic       ie2_active,
    output logic       ie1_err,
    output logic       ie2_err
);
    captura_ie_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .ERR_CYCLES (ERR_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ie1 (
        .clk    (clk),
        .rst    (rst),
        .user_sw(ie1_user_sw),
        .func_sw(ie1_func_sw),
        .btn_n  (ie1_btn_n),
        .auto_ie(auto_ie1),
        .user   (ie1_user),
        .func   (ie1_func),
        .active (ie1_active),
        .err    (ie1_err)
    );

    captura_ie_ch #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .ERR_CYCLES (ERR_CYCLES),
        .CNT_W      (CNT_W)
    ) u_ie2 (
        .clk    (clk),
        .rst    (rst),
        .user_sw(ie2_user_sw),
        .func_sw(ie2_func_sw),
        .btn_n  (ie2_btn_n),
        .auto_ie(auto_ie2),
        .user   (ie2_user),
        .func   (ie2_func),
        .active (ie2_active),
        .err    (ie2_err)
    );
endmodule

// File: tb/tb_captura_ie.sv
// Bench for captura_ie: directed scenarios plus random key/feedback traffic, compared
// every cycle against a timestamp-based session model of two DUTs sharing inputs.

module tb_captura_ie;
    localparam int DEB   = 4;
    localparam int HOLD  = 20;
    localparam int ERR_A = 3;
    localparam int ERR_B = 12;
    localparam int CW    = 26;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ie1_user_sw, ie1_func_sw, ie2_user_sw, ie2_func_sw;
    logic       ie1_btn_n, ie2_btn_n, auto_ie1, auto_ie2;
    // {ie1_user, ie1_func, ie2_user, ie2_func, ie1_active, ie2_active, ie1_err, ie2_err}
    logic [15:0] out_a, out_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    captura_ie #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .ERR_CYCLES(ERR_A), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst),
        .ie1_user_sw(ie1_user_sw), .ie1_func_sw(ie1_func_sw), .ie1_btn_n(ie1_btn_n),
        .ie2_user_sw(ie2_user_sw), .ie2_func_sw(ie2_func_sw), .ie2_btn_n(ie2_btn_n),
        .auto_ie1(auto_ie1), .auto_ie2(auto_ie2),
        .ie1_user(out_a[15:13]), .ie1_func(out_a[12:10]),
        .ie2_user(out_a[9:7]), .ie2_func(out_a[6:4]),
        .ie1_active(out_a[3]), .ie2_active(out_a[2]),
        .ie1_err(out_a[1]), .ie2_err(out_a[0])
    );

    // Second instance with a long error window so presses can land inside it.
    captura_ie #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .ERR_CYCLES(ERR_B), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst),
        .ie1_user_sw(ie1_user_sw), .ie1_func_sw(ie1_func_sw), .ie1_btn_n(ie1_btn_n),
        .ie2_user_sw(ie2_user_sw), .ie2_func_sw(ie2_func_sw), .ie2_btn_n(ie2_btn_n),
        .auto_ie1(auto_ie1), .auto_ie2(auto_ie2),
        .ie1_user(out_b[15:13]), .ie1_func(out_b[12:10]),
        .ie2_user(out_b[9:7]), .ie2_func(out_b[6:4]),
        .ie1_active(out_b[3]), .ie2_active(out_b[2]),
        .ie1_err(out_b[1]), .ie2_err(out_b[0])
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: index 0/1 = dut_a ch1/ch2, 2/3 = dut_b ch1/ch2.
    // Modes: 0 idle, 1 check, 2 active, 3 error; a session ends at edge m_end.
    int         edge_n = 0;
    int         m_mode  [4];
    int         m_end   [4];
    int         m_since [4];
    logic [2:0] m_user  [4];
    logic [2:0] m_func  [4];
    logic       m_press [4];
    logic       m_armed [4];
    logic       m_lvl   [4];
    logic       m_syn   [4][2];
    logic       m_seen  [4][DEB];

    task automatic model_step(input int k);
        logic       btn, au, all_diff;
        logic [2:0] us, fs;
        int         err_len;
        btn     = (k % 2 == 0) ? ie1_btn_n   : ie2_btn_n;
        au      = (k % 2 == 0) ? auto_ie1    : auto_ie2;
        us      = (k % 2 == 0) ? ie1_user_sw : ie2_user_sw;
        fs      = (k % 2 == 0) ? ie1_func_sw : ie2_func_sw;
        err_len = (k < 2) ? ERR_A : ERR_B;
        if (rst) begin
            m_mode[k] = 0; m_end[k] = 0; m_since[k] = 0;
            m_user[k] = 3'b000; m_func[k] = 3'b000;
            m_press[k] = 1'b0; m_armed[k] = 1'b0; m_lvl[k] = 1'b1;
            m_syn[k][0] = 1'b1; m_syn[k][1] = 1'b1;
            for (int i = 0; i < DEB; i++) m_seen[k][i] = 1'b1;
            return;
        end
        case (m_mode[k])
            0: if (m_press[k]) begin
                m_user[k] = us; m_func[k] = fs; m_mode[k] = 1;
            end
            1: if (au) begin
                m_mode[k] = 3; m_user[k] = 3'b000; m_func[k] = 3'b000;
                m_end[k] = edge_n + err_len;
            end else begin
                m_mode[k] = 2; m_end[k] = edge_n + HOLD;
            end
            2: if (m_press[k] || edge_n == m_end[k]) begin
                m_mode[k] = 0; m_user[k] = 3'b000; m_func[k] = 3'b000;
            end
            3: if (edge_n == m_end[k]) m_mode[k] = 0;
            default: m_mode[k] = 0;
        endcase
        // Level follows the synchronised key once it has disagreed for DEB samples in a row.
        for (int i = DEB - 1; i > 0; i--) m_seen[k][i] = m_seen[k][i-1];
        m_seen[k][0] = m_syn[k][1];
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_seen[k][i] == m_lvl[k]) all_diff = 1'b0;
        m_press[k] = all_diff & m_lvl[k] & m_armed[k];
        if (all_diff) m_lvl[k] = ~m_lvl[k];
        if (m_since[k] >= 2 && m_syn[k][1]) m_armed[k] = 1'b1;
        m_since[k]++;
        m_syn[k][1] = m_syn[k][0];
        m_syn[k][0] = btn;
    endtask

    function automatic logic [15:0] exp_vec(input int b);
        return {m_user[b], m_func[b], m_user[b+1], m_func[b+1],
                m_mode[b] == 2, m_mode[b+1] == 2, m_mode[b] == 3, m_mode[b+1] == 3};
    endfunction

    always @(posedge clk) begin
        edge_n++;
        for (int k = 0; k < 4; k++) model_step(k);
    end

    always @(negedge clk) begin
        check("model_a", out_a, exp_vec(0));
        check("model_b", out_b, exp_vec(2));
    end

    initial begin
        int run1, run2;
        rst = 1'b1;
        ie1_user_sw = 3'b000; ie1_func_sw = 3'b000; ie1_btn_n = 1'b1; auto_ie1 = 1'b0;
        ie2_user_sw = 3'b000; ie2_func_sw = 3'b000; ie2_btn_n = 1'b1; auto_ie2 = 1'b0;
        tick(2);
        check("reset_a", out_a, 16'h0000);
        check("reset_b", out_b, 16'h0000);
        rst = 1'b0;
        tick(6);

        // Valid commit on IE1: codes at the 7th edge, active for exactly HOLD cycles.
        ie1_user_sw = 3'b001; ie1_func_sw = 3'b010; ie1_btn_n = 1'b0;
        tick(6);
        check("commit_before", 16'(out_a[15:10]), 16'd0);
        tick(1);
        check("commit_codes", 16'(out_a[15:10]), 16'({3'b001, 3'b010}));
        check("commit_check_inactive", 16'(out_a[3]), 16'd0);
        tick(1);
        check("commit_active", 16'(out_a[3]), 16'd1);
        tick(2);
        ie1_btn_n = 1'b1;
        tick(17);
        check("hold_last", 16'({out_a[15:10], out_a[3]}), 16'({3'b001, 3'b010, 1'b1}));
        tick(1);
        check("hold_done", 16'({out_a[15:10], out_a[3], out_a[1]}), 16'd0);
        tick(10);

        // Bounce: 3 low, 1 high, 3 low never makes a press.
        ie1_btn_n = 1'b0; tick(3);
        ie1_btn_n = 1'b1; tick(1);
        ie1_btn_n = 1'b0; tick(3);
        ie1_btn_n = 1'b1; tick(12);
        check("bounce_idle", 16'({out_a[15:10], out_a[3], out_a[1]}), 16'd0);

        // Rejected request on IE2, second press lands inside dut_b's error window.
        ie2_user_sw = 3'b101; ie2_func_sw = 3'b011; auto_ie2 = 1'b1; ie2_btn_n = 1'b0;
        tick(4);
        ie2_btn_n = 1'b1;
        tick(3);
        check("reject_check_codes", 16'(out_a[9:4]), 16'({3'b101, 3'b011}));
        tick(1);
        check("reject_err", 16'({out_a[9:4], out_a[2], out_a[0]}), 16'd1);
        ie2_btn_n = 1'b0;
        tick(2);
        check("reject_err_last", 16'(out_a[0]), 16'd1);
        tick(1);
        check("reject_err_done", 16'(out_a[0]), 16'd0);
        tick(8);
        check("reject_b_err_last", 16'(out_b[0]), 16'd1);
        tick(1);
        check("reject_b_err_done", 16'({out_b[9:4], out_b[2], out_b[0]}), 16'd0);
        tick(5);
        check("reject_press_dropped", 16'({out_b[9:4], out_b[2], out_b[0]}), 16'd0);
        ie2_btn_n = 1'b1; auto_ie2 = 1'b0;
        tick(12);

        // Cancel: switch change ignored while active, second press ends the session.
        ie1_user_sw = 3'b001; ie1_func_sw = 3'b010; ie1_btn_n = 1'b0;
        tick(4);
        ie1_btn_n = 1'b1;
        tick(6);
        ie1_func_sw = 3'b111;
        tick(2);
        check("isolate_func", 16'(out_a[12:10]), 16'(3'b010));
        ie1_btn_n = 1'b0;
        tick(6);
        check("cancel_before", 16'({out_a[12:10], out_a[3]}), 16'({3'b010, 1'b1}));
        tick(1);
        check("cancel_after", 16'({out_a[15:10], out_a[3]}), 16'd0);
        ie1_btn_n = 1'b1;
        tick(12);

        // Simultaneous press, reset mid-session, keys held through reset.
        ie1_user_sw = 3'b110; ie1_func_sw = 3'b001;
        ie2_user_sw = 3'b011; ie2_func_sw = 3'b100;
        ie1_btn_n = 1'b0; ie2_btn_n = 1'b0;
        tick(8);
        check("both_active", 16'(out_a[3:0]), 16'(4'b1100));
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midreset_a", out_a, 16'h0000);
        check("midreset_b", out_b, 16'h0000);
        tick(20);
        check("held_no_session", out_a, 16'h0000);
        ie1_btn_n = 1'b1; ie2_btn_n = 1'b1;
        tick(8);
        ie1_btn_n = 1'b0; ie2_btn_n = 1'b0;
        tick(6);
        check("repress_before", out_a, 16'h0000);
        tick(1);
        check("repress_codes", 16'(out_a[15:4]), 16'({3'b110, 3'b001, 3'b011, 3'b100}));
        ie1_btn_n = 1'b1; ie2_btn_n = 1'b1;
        tick(30);

        // Random traffic: bursty keys, noisy feedback, rare resets.
        run1 = 0; run2 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run1 == 0) begin
                ie1_btn_n = 1'($urandom_range(0, 1));
                run1 = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            end
            if (run2 == 0) begin
                ie2_btn_n = 1'($urandom_range(0, 1));
                run2 = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            end
            run1--; run2--;
            if ($urandom_range(0, 7) == 0) ie1_user_sw = 3'($urandom);
            if ($urandom_range(0, 7) == 0) ie1_func_sw = 3'($urandom);
            if ($urandom_range(0, 7) == 0) ie2_user_sw = 3'($urandom);
            if ($urandom_range(0, 7) == 0) ie2_func_sw = 3'($urandom);
            auto_ie1 = ($urandom_range(0, 3) == 0);
            auto_ie2 = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
